// File: rtl/cardinal_nic.sv
`default_nettype none
// ============================================================================
//  Module   : cardinal_nic
//  Purpose  : Memory-mapped network interface for one ring node. Bridges CPU
//             register accesses to the router port through a one-entry input
//             buffer (router -> CPU) and a one-entry output buffer
//             (CPU -> router), each with a CPU-readable full flag.
//  Ports    : clk, reset (async, active-low)
//             addr/d_in/d_out/nicEn/nicWrEn  - CPU register port
//               addr 00 input buffer, 01 input status,
//               addr 10 output buffer, 11 output status
//             net_si/net_ri/net_di           - router -> NIC packet port
//             net_so/net_ro/net_do           - NIC -> router packet port
//             net_polarity                   - router's current VC polarity
//  Revision : 1.0 - initial release
// ============================================================================
module cardinal_nic #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:ADDR_W-1] addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  localparam logic [ADDR_W-1:0] C_ADDR_IN_BUF  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] C_ADDR_IN_STAT = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] C_ADDR_OUT_BUF = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] C_ADDR_OUT_STAT = ADDR_W'(3);

  logic [0:DATA_W-1] in_buf_q,  in_buf_d;
  logic              in_full_q, in_full_d;
  logic [0:DATA_W-1] out_buf_q, out_buf_d;
  logic              out_full_q, out_full_d;
  logic [0:DATA_W-1] d_out_q,   d_out_d;
  logic [0:DATA_W-1] net_do_q,  net_do_d;
  logic              net_so_q,  net_so_d;

  logic              w_rd;
  logic              w_wr;
  logic              w_accept;
  logic              w_send;

  assign w_rd     = nicEn & ~nicWrEn;
  assign w_wr     = nicEn &  nicWrEn;
  assign w_accept = net_si & ~in_full_q;
  // Bit 0 of the packet carries its virtual channel; it may only leave on
  // a cycle where the router's external polarity matches.
  assign w_send   = out_full_q & net_ro & (out_buf_q[0] == net_polarity);

  always_comb begin
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    d_out_d    = d_out_q;
    net_do_d   = net_do_q;
    net_so_d   = w_send;

    if (w_rd) begin
      unique case (addr)
        C_ADDR_IN_BUF: begin
          d_out_d   = in_buf_q;
          in_full_d = 1'b0;
        end
        C_ADDR_IN_STAT:  d_out_d = {{(DATA_W-1){1'b0}}, in_full_q};
        C_ADDR_OUT_BUF:  d_out_d = '0;
        C_ADDR_OUT_STAT: d_out_d = {{(DATA_W-1){1'b0}}, out_full_q};
        default:         d_out_d = d_out_q;
      endcase
    end

    // Accept only happens while empty, so it never races the read-clear.
    if (w_accept) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end

    // Send only happens while full, and the write is judged on the pre-edge
    // flag, so a write colliding with a send is dropped.
    if (w_send) begin
      net_do_d   = out_buf_q;
      out_full_d = 1'b0;
    end

    if (w_wr && (addr == C_ADDR_OUT_BUF) && !out_full_q) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
      d_out_q    <= '0;
      net_do_q   <= '0;
      net_so_q   <= 1'b0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
      d_out_q    <= d_out_d;
      net_do_q   <= net_do_d;
      net_so_q   <= net_so_d;
    end
  end

  assign net_ri = ~in_full_q;
  assign d_out  = d_out_q;
  assign net_do = net_do_q;
  assign net_so = net_so_q;

endmodule
`default_nettype wire

// File: tb/tb_cardinal_nic.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cardinal_nic
//  Purpose  : Self-checking bench for cardinal_nic. A queue-based model of the
//             two one-entry buffers predicts every output; directed scenarios
//             are followed by randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [0:1]  addr = '0;
  logic [0:63] d_in = '0;
  logic [0:63] d_out;
  logic        nicEn = 1'b0;
  logic        nicWrEn = 1'b0;
  logic        net_si = 1'b0;
  logic        net_ri;
  logic [0:63] net_di = '0;
  logic        net_so;
  logic        net_ro = 1'b0;
  logic [0:63] net_do;
  logic        net_polarity = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cardinal_nic #(.DATA_W(64), .ADDR_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  // ---------------- reference model ----------------
  logic [0:63] in_q[$];     // packets waiting for the CPU (max 1)
  logic [0:63] out_q[$];    // packets waiting for the router (max 1)
  logic [0:63] in_last;     // last packet ever captured (stale read value)
  logic [0:63] exp_d_out, exp_net_do;
  logic        exp_net_so;
  int          sent_count;

  task automatic model_reset();
    in_q.delete();
    out_q.delete();
    in_last    = '0;
    exp_d_out  = '0;
    exp_net_do = '0;
    exp_net_so = 1'b0;
  endtask

  task automatic model_step();
    int          pre_in, pre_out;
    logic        send;
    logic [0:63] head;
    pre_in  = in_q.size();
    pre_out = out_q.size();
    send    = 1'b0;
    if (pre_out != 0) begin
      head = out_q[0];
      send = net_ro && (head[0] == net_polarity);
    end
    exp_net_so = send;
    if (send) begin
      exp_net_do = out_q.pop_front();
      sent_count++;
    end
    if (nicEn && !nicWrEn) begin
      case (addr)
        2'd0: begin
          exp_d_out = in_last;
          if (pre_in != 0) void'(in_q.pop_front());
        end
        2'd1: exp_d_out = 64'(pre_in);
        2'd2: exp_d_out = 64'd0;
        default: exp_d_out = 64'(pre_out);
      endcase
    end
    if (nicEn && nicWrEn && addr == 2'd2 && pre_out == 0)
      out_q.push_back(d_in);
    if (net_si && pre_in == 0) begin
      in_q.push_back(net_di);
      in_last = net_di;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("d_out",  d_out,  exp_d_out);
    chk("net_so", 64'(net_so), 64'(exp_net_so));
    chk("net_do", net_do, exp_net_do);
    chk("net_ri", 64'(net_ri), 64'(in_q.size() == 0));
  endtask

  // Called at posedge+1: inputs already set, advance one edge and check.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    nicEn = 1'b0; nicWrEn = 1'b0; net_si = 1'b0; addr = 2'd0;
  endtask

  task automatic cpu_rd(input logic [1:0] a);
    idle_inputs();
    nicEn = 1'b1; addr = a;
    tick();
    idle_inputs();
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [63:0] v);
    idle_inputs();
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
    tick();
    idle_inputs();
  endtask

  task automatic rand_inputs();
    nicEn        = ($urandom_range(0, 1) == 1);
    nicWrEn      = ($urandom_range(0, 1) == 1);
    addr         = 2'($urandom_range(0, 3));
    d_in         = {$urandom, $urandom};
    net_si       = ($urandom_range(0, 1) == 1);
    net_di       = {$urandom, $urandom};
    net_ro       = ($urandom_range(0, 9) < 7);
    net_polarity = ($urandom_range(0, 1) == 1);
  endtask

  // Asynchronous reset asserted between edges, held for some random edges.
  task automatic do_reset(input int cycles);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < cycles; i++) begin
      rand_inputs();
      @(posedge clk);
      #1;
      check_all();
    end
    idle_inputs();
    net_ro = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    sent_count = 0;
    @(posedge clk);
    #1;
    do_reset(4);

    // Reset state readback
    cpu_rd(2'd3);
    chk("rst_outstat", d_out, 64'd0);
    chk("rst_ri", 64'(net_ri), 64'd1);

    // Router to CPU
    net_si = 1'b1; net_di = 64'hDEAD_BEEF_0000_0001;
    tick();
    net_si = 1'b0;
    chk("in_full_ri", 64'(net_ri), 64'd0);
    cpu_rd(2'd1);
    chk("instat_full", d_out, 64'd1);
    // Back-pressure: packet offered while full must not be taken
    net_si = 1'b1; net_di = 64'h2;
    tick();
    net_si = 1'b0;
    cpu_rd(2'd0);
    chk("rd_inbuf", d_out, 64'hDEAD_BEEF_0000_0001);
    chk("ri_after_rd", 64'(net_ri), 64'd1);
    cpu_rd(2'd1);
    chk("instat_empty", d_out, 64'd0);
    net_si = 1'b1; net_di = 64'h2;
    tick();
    net_si = 1'b0;
    cpu_rd(2'd0);
    chk("rd_inbuf2", d_out, 64'h2);
    cpu_rd(2'd0);
    chk("rd_stale", d_out, 64'h2);

    // CPU to router with polarity gating
    net_ro = 1'b1; net_polarity = 1'b0;
    cpu_wr(2'd2, 64'h8000_0000_0000_00AA);
    tick();
    chk("no_send_pol", 64'(net_so), 64'd0);
    net_polarity = 1'b1;
    tick();
    chk("send_so", 64'(net_so), 64'd1);
    chk("send_do", net_do, 64'h8000_0000_0000_00AA);
    tick();
    chk("so_pulse", 64'(net_so), 64'd0);
    cpu_rd(2'd3);
    chk("outstat_0", d_out, 64'd0);

    // Output-full drop
    net_ro = 1'b0; net_polarity = 1'b0;
    cpu_wr(2'd2, 64'h1);
    cpu_wr(2'd2, 64'h2);
    net_ro = 1'b1;
    tick();
    chk("drop_do", net_do, 64'h1);
    repeat (3) tick();
    chk("drop_once", net_do, 64'h1);

    // Write/send collision
    net_ro = 1'b0;
    cpu_wr(2'd2, 64'h4);
    net_ro = 1'b1;
    cpu_wr(2'd2, 64'h5);       // send of 4 happens here, 5 dropped
    chk("coll_do", net_do, 64'h4);
    cpu_wr(2'd2, 64'h6);
    tick();
    chk("coll_rewrite", net_do, 64'h6);

    // Mid-operation reset discards a pending packet
    net_ro = 1'b0;
    cpu_wr(2'd2, 64'h7);
    do_reset(2);
    net_ro = 1'b1; net_polarity = 1'b0;
    tick();
    chk("rst_nosend", 64'(net_so), 64'd0);
    cpu_rd(2'd3);
    chk("rst_outclr", d_out, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      if ($urandom_range(0, 499) == 0) do_reset(1);
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
